// File: rtl/l2_cache_control.sv
// l2_cache_control: direct-mapped L2 tag/valid/dirty owner sequencing hit, writeback and fill
module l2_cache_control #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_mask   = 2**s_offset,
  parameter int s_line   = 8*s_mask,
  parameter int s_tag    = 32-s_offset-s_index
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [31:0]         mem_address,
  input  logic [s_mask-1:0]   mem_wmask,
  input  logic [s_line-1:0]   mem_wdata,
  output logic [s_line-1:0]   mem_rdata,
  output logic                mem_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [31:0]         pmem_address,
  output logic [s_line-1:0]   pmem_wdata,
  input  logic [s_line-1:0]   pmem_rdata,
  input  logic                pmem_resp,
  output logic                data_read,
  output logic [s_mask-1:0]   data_write_en,
  output logic [s_index-1:0]  data_index,
  output logic [s_line-1:0]   data_datain,
  input  logic [s_line-1:0]   data_dataout
);
  localparam int num_sets = 2**s_index;
  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
  state_t state, state_n;
  logic [s_tag-1:0] tags [num_sets];
  logic [num_sets-1:0] valid, dirty;
  logic [s_index-1:0] idx;
  logic [s_tag-1:0] req_tag;
  logic hit, wr_hit, wb_done, fill_done;
  assign idx        = mem_address[s_offset +: s_index];
  assign req_tag    = mem_address[31 -: s_tag];
  assign hit        = valid[idx] && tags[idx] == req_tag;
  assign wr_hit     = state == CHECK && hit && mem_write;
  assign wb_done    = state == WRITEBACK && pmem_resp;
  assign fill_done  = state == FILL && pmem_resp;
  assign data_index = idx;
  assign mem_rdata  = data_dataout;
  assign pmem_wdata = data_dataout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (wr_hit) dirty[idx] <= 1'b1;
      if (wb_done || fill_done) dirty[idx] <= 1'b0;
      if (fill_done) valid[idx] <= 1'b1;
    end
  end
  // tags are meaningless until valid, so they need no reset
  always_ff @(posedge clk) begin
    if (fill_done) tags[idx] <= req_tag;
  end
  always_comb begin
    state_n       = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    data_read     = 1'b0;
    data_write_en = '0;
    data_datain   = mem_wdata;
    pmem_address  = {mem_address[31:s_offset], {s_offset{1'b0}}};
    case (state)
      IDLE: state_n = (mem_read || mem_write) ? CHECK : IDLE;
      CHECK: begin
        data_read     = 1'b1;
        mem_resp      = hit;
        data_write_en = wr_hit ? mem_wmask : '0;
        state_n       = hit ? IDLE : (valid[idx] && dirty[idx]) ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        data_read    = 1'b1;
        pmem_address = {tags[idx], idx, {s_offset{1'b0}}};
        state_n      = pmem_resp ? FILL : WRITEBACK;
      end
      FILL: begin
        pmem_read     = 1'b1;
        data_write_en = pmem_resp ? '1 : '0;
        data_datain   = pmem_resp ? pmem_rdata : mem_wdata;
        state_n       = pmem_resp ? CHECK : FILL;
      end
    endcase
  end
endmodule
